voice_alloc: RTL and testbench
==============================

# voice_alloc

Voice allocator and scheduler for the synth voice RAM control port. It accepts note-on/note-off events from the MIDI front end and picks which voice slot each event drives: free slot, retrigger, release or steal. It then issues one write command per event to the voice RAM port A (address, note, channel, velocity, press/release flags). The sample engine reports finished voices back through a free strobe so that slots can be reused.

## Interface

- VOICE_AW, 8: voice index width; NV = 2**VOICE_AW slots, matching voice RAM depth.

- clk32  in  1  system clock, 32 MHz.
- rst  in  1  synchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event; transfer when ev_valid && ev_ready.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  7  MIDI note.
- ev_velocity  in  7  velocity. A note-on with velocity 0 is treated as a note-off.
- ev_channel  in  4  MIDI channel.
- free_valid  in  1  sample engine reports a voice has finished its release (ADSR back to BLANK).
- free_voice  in  VOICE_AW  index of the finished voice.
- v_we  out  1  one-cycle write strobe to voice RAM port A.
- v_addr  out  VOICE_AW  target slot.
- v_note, v_channel, v_velocity  out  7/4/7  fields to write.
- v_pressed, v_released  out  1/1  note-on gives 1/0; note-off gives 0/1.
- steal  out  1  one-cycle pulse with v_we when a sounding voice was stolen.
- drop  out  1  one-cycle pulse when an event is discarded.
- active_cnt  out  VOICE_AW+1  number of occupied slots.

## Operation

- Slot table, NV entries: occupied, released, channel[3:0], note[6:0]. Asynchronous-read LUT-RAM or flops, one entry examined per cycle.
- States and transitions:
  - CLEAR: entered on reset. Zeroes one entry per cycle, 0..NV-1, then goes to IDLE.
  - IDLE: ev_ready=1. On a transfer, latch the event, set idx=0, go to SCAN.
  - SCAN: examines entry idx.
    - Note-on: record the first (lowest index) match, defined as occupied && !released && same channel/note. Also record the first free slot (!occupied) and the first released slot. Always scans all NV entries, then goes to COMMIT.
    - Note-off: on the first match, go to COMMIT. If idx=NV-1 passes with no match, pulse drop and return to IDLE with no write.
  - COMMIT: v_we=1 for one cycle, update the table entry, return to IDLE.
- Note-on target priority:
  1. Match (retrigger).
  2. Free slot. Entry becomes occupied, active_cnt+1.
  3. Released slot (steal).
  4. Slot at round-robin pointer rr (steal); rr then increments modulo NV.
- Steal cases pulse steal. Any note-on target writes the entry as occupied=1, released=0, with the new channel/note.
- Note-off target: entry released=1, occupied unchanged. The slot keeps sounding its release until free_valid.
- free_valid: clears occupied/released of free_voice and decrements active_cnt if the slot was occupied.
  - Accepted in every state except CLEAR, where it is ignored.
  - A slot freed during SCAN after idx has passed it is not reconsidered for that event.
  - If free_valid hits the same slot in the COMMIT cycle, COMMIT wins: entry ends occupied, and active_cnt counts the slot as occupied.
- active_cnt saturates at NV and 0 and never wraps.

## Timing

- Reset values:
  - ev_ready=0 (state CLEAR).
  - v_we=0, steal=0, drop=0.
  - v_addr, v_note, v_channel, v_velocity, v_pressed, v_released all 0.
  - active_cnt=0, rr=0.
- After rst deasserts: NV CLEAR cycles, then ev_ready=1.
- All outputs are registered. v_* fields are valid only while v_we=1 and hold their values otherwise.
- Event accepted at cycle T:
  - Note-on: SCAN T+1..T+NV, v_we at T+NV+1, ev_ready=1 at T+NV+2.
  - Note-off matching slot k: v_we at T+k+2.
  - Note-off miss: drop at T+NV+1.
- rst asserted mid-SCAN or mid-COMMIT: the event is abandoned, no v_we is issued, the block re-enters CLEAR.
- Throughput: at most one event per NV+2 cycles (258 cycles = 8 µs at VOICE_AW=8), well under the MIDI byte rate.

## Configuration

- VOICE_STEAL_EN defined: priority steps 3 and 4 are active (stealing as described).
- VOICE_STEAL_EN undefined:
  - A note-on with no match and no free slot pulses drop and performs no write.
  - steal is tied to 0 and rr is removed.

## Test plan

Benches run with VOICE_AW=2 (NV=4).

- Reset, then note-on ch0/n60/v100 at T → v_we at T+5, v_addr=0, v_pressed=1, active_cnt=1.
- Note-ons n60, n62, n64 → slots 0,1,2. Note-off n62 → v_we, v_addr=1, v_released=1, active_cnt still 3. free_valid slot 1 → active_cnt=2.
- Note-on n60 while it is held → retrigger slot 0, active_cnt unchanged.
- Note-on with velocity 0 for n64 behaves as a note-off → v_addr=2, v_released=1.
- Fill 4 slots, release slot 2, then note-on n70 → v_addr=2 and steal=1. With VOICE_STEAL_EN undefined: drop=1, no v_we.
- Note-off for an unheld note → drop at T+5, no v_we. Separately, free_valid on slot 0 in the same cycle as a COMMIT to slot 0 → slot stays occupied and active_cnt stays consistent.

Source files
------------

// File: rtl/voice_alloc.sv
// Voice allocator: scans the slot table one entry per cycle and issues one voice RAM write per event.
// Define VOICE_STEAL_EN to steal released / round-robin slots when no slot is free.
module voice_alloc #(
  parameter int VOICE_AW = 8
) (
  input  logic                clk32,
  input  logic                rst,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic                ev_on,
  input  logic [6:0]          ev_note,
  input  logic [6:0]          ev_velocity,
  input  logic [3:0]          ev_channel,
  input  logic                free_valid,
  input  logic [VOICE_AW-1:0] free_voice,
  output logic                v_we,
  output logic [VOICE_AW-1:0] v_addr,
  output logic [6:0]          v_note,
  output logic [3:0]          v_channel,
  output logic [6:0]          v_velocity,
  output logic                v_pressed,
  output logic                v_released,
  output logic                steal,
  output logic                drop,
  output logic [VOICE_AW:0]   active_cnt
);
  localparam int NV = 1 << VOICE_AW;
  localparam logic [VOICE_AW:0] NV_CNT = (VOICE_AW+1)'(NV);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCAN, S_COMMIT} state_t;
  state_t r_state, w_next;

  logic [NV-1:0] r_occ, r_rel;
  logic [3:0]    r_tchan [NV];
  logic [6:0]    r_tnote [NV];

  logic [VOICE_AW-1:0] r_idx;
  logic                r_on;
  logic [6:0]          r_note, r_vel;
  logic [3:0]          r_chan;
  logic                r_hit_m, r_hit_f;
  logic [VOICE_AW-1:0] r_m, r_f;

  logic                w_xfer, w_last, w_match, w_hm, w_hf;
  logic [VOICE_AW-1:0] w_m, w_f, w_on_tgt, w_addr_d;
  logic                w_on_ok, w_steal_case;
  logic                w_we_d, w_drop_d, w_steal_d;
  logic                w_inc, w_dec;

  assign w_xfer  = ev_valid && ev_ready;
  assign w_last  = &r_idx;
  assign w_match = r_occ[r_idx] && !r_rel[r_idx] &&
                   (r_tchan[r_idx] == r_chan) && (r_tnote[r_idx] == r_note);
  // Fold the entry under examination into the running "first hit" records
  assign w_hm = r_hit_m || w_match;
  assign w_m  = r_hit_m ? r_m : r_idx;
  assign w_hf = r_hit_f || !r_occ[r_idx];
  assign w_f  = r_hit_f ? r_f : r_idx;

`ifdef VOICE_STEAL_EN
  logic                r_hit_r;
  logic [VOICE_AW-1:0] r_r, r_rr;
  logic                w_hr;
  logic [VOICE_AW-1:0] w_r;

  assign w_hr         = r_hit_r || (r_occ[r_idx] && r_rel[r_idx]);
  assign w_r          = r_hit_r ? r_r : r_idx;
  assign w_on_ok      = 1'b1;
  assign w_steal_case = !w_hm && !w_hf;
  assign w_on_tgt     = w_hm ? w_m : w_hf ? w_f : w_hr ? w_r : r_rr;

  always_ff @(posedge clk32) begin
    if (rst) begin
      r_hit_r <= 1'b0;
      r_r     <= '0;
      r_rr    <= '0;
    end else begin
      if (w_xfer) r_hit_r <= 1'b0;
      else if (r_state == S_SCAN && !r_hit_r && r_occ[r_idx] && r_rel[r_idx]) begin
        r_hit_r <= 1'b1;
        r_r     <= r_idx;
      end
      if (w_steal_d && !w_hr) r_rr <= r_rr + 1'b1;
    end
  end
`else
  assign w_on_ok      = w_hm || w_hf;
  assign w_steal_case = 1'b0;
  assign w_on_tgt     = w_hm ? w_m : w_f;
`endif

  always_ff @(posedge clk32) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR:  if (w_last) w_next = S_IDLE;
      S_IDLE:   if (w_xfer) w_next = S_SCAN;
      S_SCAN: begin
        if (r_on) begin
          if (w_last) w_next = w_on_ok ? S_COMMIT : S_IDLE;
        end else if (w_match) w_next = S_COMMIT;
        else if (w_last)      w_next = S_IDLE;
      end
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_CLEAR;
    endcase
  end

  always_comb begin
    w_we_d    = 1'b0;
    w_drop_d  = 1'b0;
    w_steal_d = 1'b0;
    w_addr_d  = r_idx;
    if (r_state == S_SCAN) begin
      if (r_on) begin
        w_addr_d = w_on_tgt;
        if (w_last) begin
          w_we_d    = w_on_ok;
          w_drop_d  = !w_on_ok;
          w_steal_d = w_steal_case;
        end
      end else begin
        w_we_d   = w_match;
        w_drop_d = !w_match && w_last;
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      ev_ready   <= 1'b0;
      v_we       <= 1'b0;
      steal      <= 1'b0;
      drop       <= 1'b0;
      v_addr     <= '0;
      v_note     <= '0;
      v_channel  <= '0;
      v_velocity <= '0;
      v_pressed  <= 1'b0;
      v_released <= 1'b0;
    end else begin
      ev_ready <= (w_next == S_IDLE);
      v_we     <= w_we_d;
      steal    <= w_steal_d;
      drop     <= w_drop_d;
      if (w_we_d) begin
        v_addr     <= w_addr_d;
        v_note     <= r_note;
        v_channel  <= r_chan;
        v_velocity <= r_vel;
        v_pressed  <= r_on;
        v_released <= !r_on;
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      r_idx   <= '0;
      r_on    <= 1'b0;
      r_note  <= '0;
      r_vel   <= '0;
      r_chan  <= '0;
      r_hit_m <= 1'b0;
      r_hit_f <= 1'b0;
      r_m     <= '0;
      r_f     <= '0;
    end else begin
      if (r_state == S_CLEAR || r_state == S_SCAN) r_idx <= r_idx + 1'b1;
      if (w_xfer) begin
        r_idx   <= '0;
        r_on    <= ev_on && (ev_velocity != 7'd0);
        r_note  <= ev_note;
        r_vel   <= ev_velocity;
        r_chan  <= ev_channel;
        r_hit_m <= 1'b0;
        r_hit_f <= 1'b0;
      end else if (r_state == S_SCAN) begin
        if (!r_hit_m && w_match) begin
          r_hit_m <= 1'b1;
          r_m     <= r_idx;
        end
        if (!r_hit_f && !r_occ[r_idx]) begin
          r_hit_f <= 1'b1;
          r_f     <= r_idx;
        end
      end
    end
  end

  // Commit is written after the free so it wins on a same-slot collision
  always_ff @(posedge clk32) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_occ[r_idx]   <= 1'b0;
        r_rel[r_idx]   <= 1'b0;
        r_tchan[r_idx] <= '0;
        r_tnote[r_idx] <= '0;
      end else begin
        if (free_valid) begin
          r_occ[free_voice] <= 1'b0;
          r_rel[free_voice] <= 1'b0;
        end
        if (r_state == S_COMMIT) begin
          if (v_pressed) begin
            r_occ[v_addr]   <= 1'b1;
            r_rel[v_addr]   <= 1'b0;
            r_tchan[v_addr] <= v_channel;
            r_tnote[v_addr] <= v_note;
          end else begin
            r_occ[v_addr] <= r_occ[v_addr];
            r_rel[v_addr] <= 1'b1;
          end
        end
      end
    end
  end

  assign w_inc = (r_state == S_COMMIT) && v_pressed && !r_occ[v_addr];
  assign w_dec = free_valid && (r_state != S_CLEAR) && r_occ[free_voice] &&
                 !((r_state == S_COMMIT) && (free_voice == v_addr));

  always_ff @(posedge clk32) begin
    if (rst) active_cnt <= '0;
    else if (w_inc && !w_dec && active_cnt != NV_CNT) active_cnt <= active_cnt + 1'b1;
    else if (w_dec && !w_inc && active_cnt != '0)     active_cnt <= active_cnt - 1'b1;
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc at VOICE_AW=2: directed steps then random events against a slot-table model.
module tb_voice_alloc;
  localparam int AW = 2;
  localparam int NV = 1 << AW;

  logic          clk32 = 1'b0;
  logic          rst = 1'b1;
  logic          ev_valid = 1'b0, ev_on = 1'b0;
  logic [6:0]    ev_note = '0, ev_velocity = '0;
  logic [3:0]    ev_channel = '0;
  logic          free_valid = 1'b0;
  logic [AW-1:0] free_voice = '0;
  logic          ev_ready, v_we, v_pressed, v_released, steal, drop;
  logic [AW-1:0] v_addr;
  logic [6:0]    v_note, v_velocity;
  logic [3:0]    v_channel;
  logic [AW:0]   active_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bit m_occ [NV];
  bit m_rel [NV];
  int m_ch  [NV];
  int m_nt  [NV];
  int m_rr;

  always #5 clk32 = ~clk32;

  voice_alloc #(.VOICE_AW(AW)) dut (
    .clk32(clk32), .rst(rst),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on), .ev_note(ev_note),
    .ev_velocity(ev_velocity), .ev_channel(ev_channel),
    .free_valid(free_valid), .free_voice(free_voice),
    .v_we(v_we), .v_addr(v_addr), .v_note(v_note), .v_channel(v_channel),
    .v_velocity(v_velocity), .v_pressed(v_pressed), .v_released(v_released),
    .steal(steal), .drop(drop), .active_cnt(active_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_cnt();
    int n;
    n = 0;
    for (int i = 0; i < NV; i++) if (m_occ[i]) n++;
    return n;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NV; i++) begin
      m_occ[i] = 1'b0; m_rel[i] = 1'b0; m_ch[i] = 0; m_nt[i] = 0;
    end
    m_rr = 0;
  endtask

  // Reference allocation: cycle-level latency counted from the negedge after the transfer edge
  task automatic model_event(input bit on_in, input int note, input int vel, input int ch,
                             output bit wr, output int addr, output bit stl, output int lat);
    bit on;
    int m, f, r;
    on = on_in && (vel != 0);
    m = -1; f = -1; r = -1;
    wr = 1'b0; addr = 0; stl = 1'b0; lat = NV + 1;
    for (int i = 0; i < NV; i++) begin
      if (m < 0 && m_occ[i] && !m_rel[i] && m_ch[i] == ch && m_nt[i] == note) m = i;
      if (f < 0 && !m_occ[i]) f = i;
      if (r < 0 && m_occ[i] && m_rel[i]) r = i;
    end
    if (!on) begin
      if (m >= 0) begin
        wr = 1'b1; addr = m; lat = m + 2; m_rel[m] = 1'b1;
      end
    end else begin
      if (m >= 0)      begin wr = 1'b1; addr = m; end
      else if (f >= 0) begin wr = 1'b1; addr = f; end
`ifdef VOICE_STEAL_EN
      else if (r >= 0) begin wr = 1'b1; addr = r; stl = 1'b1; end
      else begin wr = 1'b1; addr = m_rr; stl = 1'b1; m_rr = (m_rr + 1) % NV; end
`endif
      if (wr) begin
        m_occ[addr] = 1'b1; m_rel[addr] = 1'b0; m_ch[addr] = ch; m_nt[addr] = note;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk32);
    rst = 1'b1; ev_valid = 1'b0; free_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk32);
      chk($sformatf("%s.we_in_rst", tag), v_we, 0);
    end
    chk($sformatf("%s.ready", tag), ev_ready, 0);
    chk($sformatf("%s.pulses", tag), {steal, drop}, 0);
    chk($sformatf("%s.fields", tag),
        {v_pressed, v_released, v_addr, v_note, v_channel, v_velocity}, 0);
    chk($sformatf("%s.cnt", tag), active_cnt, 0);
    rst = 1'b0;
    for (int c = 1; c <= NV; c++) begin
      @(negedge clk32);
      chk($sformatf("%s.clear%0d", tag, c), ev_ready, (c == NV));
    end
    m_clear();
  endtask

  task automatic run_event(input string tag, input bit on, input int note, input int vel,
                           input int ch, input int free_slot);
    bit wr, stl;
    int addr, lat, w, seen, n_we, n_drop, n_steal;
    logic [31:0] c_addr, c_note, c_ch, c_vel, c_pr, c_rl;
    w = 0;
    while (ev_ready !== 1'b1 && w < 3 * NV) begin @(negedge clk32); w++; end
    chk($sformatf("%s.ready", tag), ev_ready, 1);
    model_event(on, note, vel, ch, wr, addr, stl, lat);
    ev_valid = 1'b1; ev_on = on; ev_note = 7'(note); ev_velocity = 7'(vel); ev_channel = 4'(ch);
    @(posedge clk32);
    seen = 0; n_we = 0; n_drop = 0; n_steal = 0;
    c_addr = 0; c_note = 0; c_ch = 0; c_vel = 0; c_pr = 0; c_rl = 0;
    for (int c = 1; c <= NV + 2; c++) begin
      @(negedge clk32);
      ev_valid = 1'b0; free_valid = 1'b0;
      if (v_we === 1'b1)  n_we++;
      if (drop === 1'b1)  n_drop++;
      if (steal === 1'b1) n_steal++;
      if (seen == 0 && (v_we === 1'b1 || drop === 1'b1)) begin
        seen = c;
        c_addr = v_addr; c_note = v_note; c_ch = v_channel; c_vel = v_velocity;
        c_pr = v_pressed; c_rl = v_released;
        if (v_we === 1'b1 && free_slot >= 0) begin
          free_valid = 1'b1; free_voice = AW'(free_slot);
        end
      end
    end
    free_valid = 1'b0;
    if (free_slot >= 0 && wr && free_slot != addr) begin
      m_occ[free_slot] = 1'b0; m_rel[free_slot] = 1'b0;
    end
    chk($sformatf("%s.latency", tag), seen, lat);
    chk($sformatf("%s.n_we", tag), n_we, wr);
    chk($sformatf("%s.n_drop", tag), n_drop, !wr);
    chk($sformatf("%s.n_steal", tag), n_steal, stl);
    if (wr) begin
      chk($sformatf("%s.addr", tag), c_addr, addr);
      chk($sformatf("%s.press_rel", tag), {c_pr[0], c_rl[0]},
          (on && vel != 0) ? 2'b10 : 2'b01);
      chk($sformatf("%s.note_ch_vel", tag), {c_note[6:0], c_ch[3:0], c_vel[6:0]},
          {7'(note), 4'(ch), 7'(vel)});
    end
    chk($sformatf("%s.cnt", tag), active_cnt, m_cnt());
  endtask

  task automatic do_free(input string tag, input int slot);
    @(negedge clk32);
    free_valid = 1'b1; free_voice = AW'(slot);
    @(negedge clk32);
    free_valid = 1'b0;
    m_occ[slot] = 1'b0; m_rel[slot] = 1'b0;
    chk($sformatf("%s.cnt", tag), active_cnt, m_cnt());
  endtask

  initial begin
    int rn, rv, rc, rf;
    bit ron;
    m_clear();
    do_reset("rst0");
    run_event("on60", 1'b1, 60, 100, 0, -1);
    run_event("on62", 1'b1, 62, 90, 0, -1);
    run_event("on64", 1'b1, 64, 80, 0, -1);
    run_event("off62", 1'b0, 62, 0, 0, -1);
    do_free("free1", 1);
    run_event("retrig60", 1'b1, 60, 70, 0, -1);
    run_event("v0off64", 1'b1, 64, 0, 0, -1);

    do_reset("rst1");
    run_event("fill60", 1'b1, 60, 100, 0, -1);
    run_event("fill62", 1'b1, 62, 100, 0, -1);
    run_event("fill64", 1'b1, 64, 100, 0, -1);
    run_event("fill66", 1'b1, 66, 100, 0, -1);
    run_event("off64", 1'b0, 64, 50, 0, -1);
    run_event("on70", 1'b1, 70, 100, 0, -1);
    run_event("on72", 1'b1, 72, 100, 0, -1);
    run_event("offmiss", 1'b0, 99, 0, 5, -1);

    do_reset("rst2");
    run_event("c_on60", 1'b1, 60, 100, 0, -1);
    run_event("c_retrig60", 1'b1, 60, 100, 0, 0);
    run_event("c_on61", 1'b1, 61, 100, 0, 1);
    run_event("c_off60", 1'b0, 60, 0, 0, -1);

    // reset lands mid-scan: the pending note-on must never be written
    @(negedge clk32);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd50; ev_velocity = 7'd90; ev_channel = 4'd2;
    @(posedge clk32);
    @(negedge clk32); ev_valid = 1'b0;
    chk("midscan.we", v_we, 0);
    do_reset("rst_midscan");
    run_event("after_rst", 1'b1, 50, 90, 2, -1);

    for (int i = 0; i < 60; i++) begin
      ron = ($urandom_range(0, 99) < 60);
      rn  = 60 + $urandom_range(0, 3);
      rc  = $urandom_range(0, 1);
      rv  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 127);
      rf  = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, NV - 1)) : -1;
      run_event($sformatf("rnd%0d", i), ron, rn, rv, rc, rf);
      if ($urandom_range(0, 3) == 0) do_free($sformatf("rndfree%0d", i), $urandom_range(0, NV - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
